mmio_timer: RTL and testbench



---
 rtl/mmio_timer.sv | 109 ++++++++++
 tb/tb_mmio_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral: prescaled counter, compare match with
// optional auto-reload, sticky W1C status flags and a level interrupt.
module mmio_timer #(
    parameter int                 WIDTH         = 32,
    parameter logic [WIDTH-1:0]   BASE_ADDR     = 32'h0000_0600,
    parameter int                 PRESCALE_BITS = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] ADDRESS,
    input  logic [WIDTH-1:0] WRITE_DATA,
    input  logic             WRITE_READ,
    output logic [WIDTH-1:0] READ_DATA,
    output logic             SEL,
    output logic             IRQ
);

    logic [2:0]               ctrl;
    logic [PRESCALE_BITS-1:0] prescale;
    logic [PRESCALE_BITS-1:0] pre_cnt;
    logic [WIDTH-1:0]         count;
    logic [WIDTH-1:0]         compare;
    logic                     match_flag;
    logic                     ovf_flag;

    logic [2:0]       offset;
    logic             wr;
    logic             wr_ctrl, wr_pre, wr_count, wr_cmp, wr_status;
    logic             tick;
    logic             at_compare, at_max;
    logic             set_match, set_ovf;
    logic [WIDTH-1:0] count_next;

    assign SEL    = (ADDRESS[WIDTH-1:3] == BASE_ADDR[WIDTH-1:3]);
    assign offset = ADDRESS[2:0];
    assign wr     = SEL & WRITE_READ;

    assign wr_ctrl   = wr && (offset == 3'd0);
    assign wr_pre    = wr && (offset == 3'd1);
    assign wr_count  = wr && (offset == 3'd2);
    assign wr_cmp    = wr && (offset == 3'd3);
    assign wr_status = wr && (offset == 3'd4);

    assign tick       = ctrl[0] && (pre_cnt == prescale);
    assign at_compare = (count == compare);
    assign at_max     = &count;

    // A software write to COUNT on a tick discards that tick's flag updates.
    assign set_match = tick & at_compare & ~wr_count;
    assign set_ovf   = tick & ~at_compare & at_max & ~wr_count;

    // Without a reload, COUNT+1 wraps FFFF_FFFF to 0 on its own.
    always_comb begin
        count_next = count;
        if (wr_count)
            count_next = WRITE_DATA;
        else if (tick)
            count_next = (at_compare && ctrl[1]) ? '0 : count + WIDTH'(1);
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            ctrl       <= '0;
            prescale   <= '0;
            pre_cnt    <= '0;
            count      <= '0;
            compare    <= '1;
            match_flag <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= WRITE_DATA[2:0];
            if (wr_pre)  prescale <= WRITE_DATA[PRESCALE_BITS-1:0];
            if (wr_cmp)  compare <= WRITE_DATA;

            if (wr_pre || !ctrl[0] || tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + PRESCALE_BITS'(1);

            count <= count_next;

            // Set beats a simultaneous W1C clear.
            if (wr_status) begin
                match_flag <= (match_flag & ~WRITE_DATA[0]) | set_match;
                ovf_flag   <= (ovf_flag & ~WRITE_DATA[1]) | set_ovf;
            end else begin
                match_flag <= match_flag | set_match;
                ovf_flag   <= ovf_flag | set_ovf;
            end
        end
    end

    always_comb begin
        READ_DATA = '0;
        if (SEL) begin
            case (offset)
                3'd0:    READ_DATA = {{(WIDTH-3){1'b0}}, ctrl};
                3'd1:    READ_DATA = {{(WIDTH-PRESCALE_BITS){1'b0}}, prescale};
                3'd2:    READ_DATA = count;
                3'd3:    READ_DATA = compare;
                3'd4:    READ_DATA = {{(WIDTH-2){1'b0}}, ovf_flag, match_flag};
                default: READ_DATA = '0;
            endcase
        end
    end

    assign IRQ = ctrl[2] & match_flag;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: a cycle-level behavioural model checked on every falling
// edge, plus directed scenarios with hand-computed literal expectations.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_0600;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] ADDRESS = 32'h0;
    logic [31:0] WRITE_DATA = 32'h0;
    logic        WRITE_READ = 1'b0;
    logic [31:0] READ_DATA;
    logic        SEL;
    logic        IRQ;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_timer #(
        .WIDTH(32), .BASE_ADDR(BASE), .PRESCALE_BITS(16)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .WRITE_READ(WRITE_READ), .READ_DATA(READ_DATA), .SEL(SEL), .IRQ(IRQ)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register file plus a count of cycles into the current prescale period.
    logic [2:0]  m_ctrl  = 3'b0;
    int          m_pscale = 0;
    int          m_phase  = 0;
    logic [31:0] m_count = 32'h0;
    logic [31:0] m_cmp   = 32'hFFFF_FFFF;
    logic        m_match = 1'b0;
    logic        m_ovf   = 1'b0;

    always @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            m_ctrl   <= 3'b0;
            m_pscale <= 0;
            m_phase  <= 0;
            m_count  <= 32'h0;
            m_cmp    <= 32'hFFFF_FFFF;
            m_match  <= 1'b0;
            m_ovf    <= 1'b0;
        end else begin : step
            logic        hit, wr, tick, sm, so;
            logic [2:0]  off;
            logic [31:0] nxt;
            hit  = (ADDRESS[31:3] == BASE[31:3]);
            wr   = hit && WRITE_READ;
            off  = ADDRESS[2:0];
            tick = m_ctrl[0] && (m_phase == m_pscale);
            sm   = 1'b0;
            so   = 1'b0;
            nxt  = m_count;
            if (tick) begin
                if (m_count == m_cmp) begin
                    sm  = 1'b1;
                    nxt = m_ctrl[1] ? 32'h0 : m_count + 32'h1;
                end else if (m_count == 32'hFFFF_FFFF) begin
                    so  = 1'b1;
                    nxt = 32'h0;
                end else begin
                    nxt = m_count + 32'h1;
                end
            end
            if (wr && off == 3'd2) begin
                nxt = WRITE_DATA;
                sm  = 1'b0;
                so  = 1'b0;
            end
            m_count <= nxt;
            m_phase <= ((wr && off == 3'd1) || !m_ctrl[0] || tick) ? 0 : m_phase + 1;
            if (wr && off == 3'd0) m_ctrl <= WRITE_DATA[2:0];
            if (wr && off == 3'd1) m_pscale <= int'(WRITE_DATA[15:0]);
            if (wr && off == 3'd3) m_cmp <= WRITE_DATA;
            if (wr && off == 3'd4) begin
                m_match <= (m_match && !WRITE_DATA[0]) || sm;
                m_ovf   <= (m_ovf && !WRITE_DATA[1]) || so;
            end else begin
                m_match <= m_match || sm;
                m_ovf   <= m_ovf || so;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a[31:3] != BASE[31:3]) return 32'h0;
        case (a[2:0])
            3'd0:    return {29'h0, m_ctrl};
            3'd1:    return m_pscale[31:0];
            3'd2:    return m_count;
            3'd3:    return m_cmp;
            3'd4:    return {30'h0, m_ovf, m_match};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge CLOCK) begin
        check("model_sel", {31'h0, SEL}, {31'h0, ADDRESS[31:3] == BASE[31:3]});
        check("model_rdata", READ_DATA, exp_rd(ADDRESS));
        check("model_irq", {31'h0, IRQ}, {31'h0, m_ctrl[2] & m_match});
    end

    task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
        ADDRESS    = BASE + {29'h0, off};
        WRITE_DATA = d;
        WRITE_READ = 1'b1;
        @(posedge CLOCK);
        #1;
        WRITE_READ = 1'b0;
        WRITE_DATA = 32'h0;
        ADDRESS    = BASE + 32'h2;
    endtask

    task automatic bus_read(input logic [2:0] off, input logic [31:0] exp, input string name);
        ADDRESS    = BASE + {29'h0, off};
        WRITE_READ = 1'b0;
        #1;
        check(name, READ_DATA, exp);
    endtask

    logic [31:0] reload_seq [7] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};

    initial begin
        // Reset and readback
        repeat (2) @(posedge CLOCK);
        #1;
        check("irq_in_reset", {31'h0, IRQ}, 32'h0);
        #2 RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        for (int o = 0; o < 8; o++) begin
            bus_read(3'(o), (o == 3) ? 32'hFFFF_FFFF : 32'h0, "reset_readback");
            @(posedge CLOCK);
            #1;
        end
        ADDRESS = 32'h0000_0500;
        #1;
        check("outside_sel", {31'h0, SEL}, 32'h0);
        check("outside_rdata", READ_DATA, 32'h0);

        // Prescaled counting: tick every 4th cycle, 40 cycles -> 10 ticks
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'd1);
        repeat (40) @(posedge CLOCK);
        #1;
        bus_read(3'd2, 32'd10, "prescaled_count");
        bus_write(3'd0, 32'd0);
        repeat (20) @(posedge CLOCK);
        #1;
        bus_read(3'd2, 32'd10, "frozen_count");

        // Compare with auto-reload
        bus_write(3'd1, 32'd0);
        bus_write(3'd2, 32'd0);
        bus_write(3'd3, 32'd5);
        bus_write(3'd0, 32'd7);
        for (int i = 0; i < 7; i++) begin
            @(posedge CLOCK);
            #1;
            check("reload_count", READ_DATA, reload_seq[i]);
            check("reload_irq", {31'h0, IRQ}, (i >= 5) ? 32'h1 : 32'h0);
        end
        bus_read(3'd4, 32'h1, "reload_status");
        bus_write(3'd4, 32'h1);
        check("irq_after_w1c", {31'h0, IRQ}, 32'h0);
        bus_read(3'd4, 32'h0, "status_after_w1c");
        bus_write(3'd0, 32'd0);

        // Overflow without reload
        bus_write(3'd2, 32'hFFFF_FFFE);
        bus_write(3'd3, 32'h0);
        bus_write(3'd1, 32'h0);
        bus_write(3'd0, 32'h1);
        @(posedge CLOCK);
        #1;
        @(posedge CLOCK);
        #1;
        bus_read(3'd2, 32'h0, "ovf_count");
        bus_read(3'd4, 32'h2, "ovf_status");
        @(posedge CLOCK);
        #1;
        bus_read(3'd2, 32'h1, "match_no_reload_count");
        bus_read(3'd4, 32'h3, "match_no_reload_status");
        check("irq_disabled", {31'h0, IRQ}, 32'h0);
        bus_write(3'd0, 32'h0);
        bus_write(3'd4, 32'h3);

        // Collisions: COUNT write on a tick, W1C on the cycle MATCH sets
        bus_write(3'd0, 32'h1);
        bus_write(3'd2, 32'h100);
        bus_read(3'd2, 32'h100, "count_write_wins");
        bus_read(3'd4, 32'h0, "no_flag_on_write_tick");
        bus_write(3'd0, 32'h0);
        bus_read(3'd2, 32'h101, "count_after_write");
        bus_write(3'd2, 32'h104);
        bus_write(3'd3, 32'h105);
        bus_write(3'd0, 32'h1);
        @(posedge CLOCK);
        #1;
        bus_write(3'd4, 32'h1);
        bus_read(3'd4, 32'h1, "set_beats_w1c");
        bus_read(3'd2, 32'h106, "count_past_match");

        // Auto-reload at COMPARE = FFFF_FFFF never sets OVF
        bus_write(3'd0, 32'h0);
        bus_write(3'd4, 32'h3);
        bus_write(3'd2, 32'hFFFF_FFFE);
        bus_write(3'd3, 32'hFFFF_FFFF);
        bus_write(3'd0, 32'h3);
        @(posedge CLOCK);
        #1;
        bus_read(3'd2, 32'hFFFF_FFFF, "max_count");
        @(posedge CLOCK);
        #1;
        bus_read(3'd2, 32'h0, "reload_at_max");
        bus_read(3'd4, 32'h1, "reload_no_ovf");

        // Asynchronous reset while IRQ is high
        bus_write(3'd0, 32'h0);
        bus_write(3'd4, 32'h3);
        bus_write(3'd2, 32'h0);
        bus_write(3'd3, 32'h2);
        bus_write(3'd0, 32'h7);
        repeat (4) @(posedge CLOCK);
        #1;
        check("irq_before_reset", {31'h0, IRQ}, 32'h1);
        bus_read(3'd2, 32'h1, "count_before_reset");
        #1 RESET = 1'b0;
        #1;
        check("irq_async_reset", {31'h0, IRQ}, 32'h0);
        check("count_async_reset", READ_DATA, 32'h0);
        #3 RESET = 1'b1;
        @(posedge CLOCK);
        #1;
        bus_read(3'd3, 32'hFFFF_FFFF, "compare_after_reset");
        bus_read(3'd0, 32'h0, "ctrl_after_reset");

        repeat (3) @(posedge CLOCK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
